diff_accum: RTL and testbench
=============================

# diff_accum

Windowed accumulator that sits directly downstream of the subtractor stage: it consumes a DTI stream of difference values and emits one sum per `CNT` consecutive input samples. Used to build difference-sum / sum-of-absolute-differences reductions after `sub`. Output is registered, and the block sustains one input per cycle across window boundaries.

## Interface
- `DIN`, 16: input data width (bits); must be ≥ 1.
- `DIN_SIGNED`, 0: 1 = input is two's complement; 0 = unsigned.
- `CNT`, 4: samples per window; must be ≥ 1.
- Derived `DOUT` = `DIN + $clog2(CNT)`, which equals `DIN` when `CNT` = 1.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `din`  dti.consumer  `DIN`  difference samples: `data`, `valid`, `ready`.
- `dout`  dti.producer  `DOUT`  window sums: `data`, `valid`, `ready`. Signedness of `dout.data` follows `DIN_SIGNED`, except when the abs feature is compiled in (then it is always unsigned).

## Operation
- Registers:
  - `acc` (`DOUT` bits): running sum.
  - `cnt` (0..`CNT`-1): samples accepted in the current window.
  - `res` (`DOUT` bits): drives `dout.data`.
  - `state`.
- Input extension: `din.data` is sign-extended to `DOUT` bits if `DIN_SIGNED`, else zero-extended.
- Arithmetic is modulo 2^`DOUT`. The width guarantees no overflow for any `CNT` samples.
- States:
  - **ACC**:
    - `din.ready` = 1; `dout.valid` = 0.
    - On a `din` handshake with `cnt` < `CNT`-1: `acc` += ext(data), `cnt` += 1.
    - On a `din` handshake with `cnt` = `CNT`-1: `res` = `acc` + ext(data), `acc` = 0, `cnt` = 0, go to OUT.
  - **OUT**:
    - `dout.valid` = 1; `din.ready` = `dout.ready`. This is a combinational ready path; no path exists from `din.valid` to `dout.valid`.
    - `dout.ready` = 0: hold all state; `dout.data` stays stable.
    - `dout` handshake without `din.valid`: go to ACC.
    - `dout` handshake with `din.valid` (simultaneous): the sample starts the next window, i.e. `acc` = ext(data), `cnt` = 1, go to ACC.
    - If `CNT` = 1, the simultaneous case instead loads `res` = ext(data) and stays in OUT.
- Reset (any cycle, including mid-window or while OUT is stalled):
  - `state` = ACC; `acc`, `cnt`, `res` = 0.
  - `dout.valid` = 0, `dout.data` = 0.
  - Partial window sums and pending outputs are discarded.
  - `din.ready` reads 1 in the cycle after reset is released.

## Timing
- Latency: `dout.valid` rises on the first clock edge after the handshake of a window's last sample.
- Throughput: one sample per cycle while `dout.ready` = 1. Back-to-back windows produce no bubble on `din`.
- `dout.valid`, once high, stays high with stable `data` until a handshake or reset.
- `din.valid` may drop without a handshake; `cnt` does not advance on non-handshake cycles.
- Reset values of outputs: `dout.valid` 0, `dout.data` 0.

## Configuration
- Macro: `DIFF_ACCUM_ABS_EN`.
- Defined: each extended sample is replaced by its absolute value before the add (sum of absolute differences).
  - Absolute value is computed in `DOUT` width, so −2^(`DIN`−1) maps to +2^(`DIN`−1) without overflow.
  - `dout.data` is always unsigned.
  - Unsigned input passes through unchanged.
- Undefined: plain signed/unsigned sum as described above; no abs logic is instantiated.

## Test plan
- Unsigned sum: `DIN`=8, `CNT`=4, unsigned, `dout.ready`=1. Feed 1, 2, 3, 4 on consecutive cycles → `dout.data`=10 (`DOUT`=10), valid one cycle after the 4th sample, for exactly one cycle.
- Signed sum: `DIN_SIGNED`=1, inputs −3, 5, −7, 1 → `dout.data`=0x3FC (−4).
  - With `DIFF_ACCUM_ABS_EN`: same inputs → 16.
  - With `DIFF_ACCUM_ABS_EN`: four samples of −128 → 512.
- Backpressure: complete a window, hold `dout.ready`=0 for 5 cycles → `din.ready`=0, `dout.data` stable, `cnt` unchanged. Raise `dout.ready` together with a valid sample 7 → handshake on both; the next window starts with `acc`=7.
- Back-to-back windows: 8 samples of value 1 on cycles 0–7, `dout.ready`=1 → outputs of 4 on cycles 4 and 8; `din.ready` never deasserts.
- Reset mid-window: accept 9, 9, assert `rst` for one cycle, then feed 1, 1, 1, 1 → single output of 4. Also assert `rst` while OUT is stalled → `dout.valid`=0 on the next cycle.
- `CNT`=1: stream 5, 6, 7 with `dout.ready`=1 → outputs 5, 6, 7 on consecutive cycles, one-cycle latency, no bubbles.

Source files
------------

// File: rtl/diff_accum.sv
// diff_accum: windowed accumulator that emits one registered sum per CNT accepted samples.
// Optional feature macro DIFF_ACCUM_ABS_EN: accumulate absolute values (sum of absolute differences).
module diff_accum #(
   parameter int DIN        = 16,
   parameter int DIN_SIGNED = 0,
   parameter int CNT        = 4,
   localparam int DOUT      = DIN + $clog2(CNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DIN-1:0]  din_data,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [DOUT-1:0] dout_data,
   output logic            dout_valid,
   input  logic            dout_ready
);

   localparam int CW = (CNT > 1) ? $clog2(CNT) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT - 1);

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [DOUT-1:0] acc_q, acc_d;
   logic [DOUT-1:0] res_q, res_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DOUT-1:0] sample_ext;

   function automatic logic [DOUT-1:0] ext_sample(input logic [DIN-1:0] d);
      logic [DOUT-1:0] e;
      if (DIN_SIGNED != 0) begin
         e = DOUT'($signed(d));
      end else begin
         e = DOUT'(d);
      end
`ifdef DIFF_ACCUM_ABS_EN
      // Negation in DOUT width keeps -2^(DIN-1) representable.
      e = ((DIN_SIGNED != 0) && e[DOUT-1]) ? -e : e;
`endif
      return e;
   endfunction

   assign sample_ext = ext_sample(din_data);
   assign dout_valid = (state_q == ST_OUT);
   assign dout_data  = res_q;

   // Next-state, accumulator and input-ready logic.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      din_ready = 1'b1;
      case (state_q)
         ST_ACC: begin
            din_ready = 1'b1;
            if (din_valid) begin
               if (cnt_q == CNT_LAST) begin
                  res_d   = acc_q + sample_ext;
                  acc_d   = {DOUT{1'b0}};
                  cnt_d   = {CW{1'b0}};
                  state_d = ST_OUT;
               end else begin
                  acc_d = acc_q + sample_ext;
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_OUT: begin
            // Ready passes straight through so a new window can start during the output handshake.
            din_ready = dout_ready;
            if (dout_ready) begin
               if (din_valid) begin
                  if (CNT == 1) begin
                     res_d   = sample_ext;
                     state_d = ST_OUT;
                  end else begin
                     acc_d   = sample_ext;
                     cnt_d   = CNT_ONE;
                     state_d = ST_ACC;
                  end
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d   = ST_ACC;
            acc_d     = {DOUT{1'b0}};
            cnt_d     = {CW{1'b0}};
            res_d     = {DOUT{1'b0}};
            din_ready = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         acc_q   <= {DOUT{1'b0}};
         cnt_q   <= {CW{1'b0}};
         res_q   <= {DOUT{1'b0}};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_diff_accum.sv
// Testbench for diff_accum: three instances (unsigned CNT=4, signed CNT=4, signed CNT=1) against a window-sum model.
module tb_diff_accum;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_data   [3];
   logic       din_valid  [3];
   logic       dout_ready [3];

   logic       rdy0, rdy1, rdy2;
   logic       vld0, vld1, vld2;
   logic [9:0] dat0, dat1;
   logic [7:0] dat2;

   int checks = 0;
   int errors = 0;

   // Reference model: samples in current window, running sum, pending result.
   int m_n    [3];
   int m_sum  [3];
   bit m_pend [3];
   int m_res  [3];

   always #5 clk = ~clk;

   diff_accum #(.DIN(8), .DIN_SIGNED(0), .CNT(4)) u0 (
      .clk(clk), .rst(rst), .din_data(din_data[0]), .din_valid(din_valid[0]), .din_ready(rdy0),
      .dout_data(dat0), .dout_valid(vld0), .dout_ready(dout_ready[0]));
   diff_accum #(.DIN(8), .DIN_SIGNED(1), .CNT(4)) u1 (
      .clk(clk), .rst(rst), .din_data(din_data[1]), .din_valid(din_valid[1]), .din_ready(rdy1),
      .dout_data(dat1), .dout_valid(vld1), .dout_ready(dout_ready[1]));
   diff_accum #(.DIN(8), .DIN_SIGNED(1), .CNT(1)) u2 (
      .clk(clk), .rst(rst), .din_data(din_data[2]), .din_valid(din_valid[2]), .din_ready(rdy2),
      .dout_data(dat2), .dout_valid(vld2), .dout_ready(dout_ready[2]));

   function automatic int cnt_of(int k);
      return (k == 2) ? 1 : 4;
   endfunction

   function automatic int mask_of(int k);
      return (k == 2) ? 32'h0FF : 32'h3FF;
   endfunction

   function automatic int ext_val(int k, logic [7:0] d);
      int v;
      v = (k != 0) ? int'($signed(d)) : int'({24'd0, d});
`ifdef DIFF_ACCUM_ABS_EN
      if (v < 0) v = -v;
`endif
      return v;
   endfunction

   function automatic logic [31:0] get_vld(int k);
      case (k)
         0: return {31'd0, vld0};
         1: return {31'd0, vld1};
         default: return {31'd0, vld2};
      endcase
   endfunction

   function automatic logic [31:0] get_rdy(int k);
      case (k)
         0: return {31'd0, rdy0};
         1: return {31'd0, rdy1};
         default: return {31'd0, rdy2};
      endcase
   endfunction

   function automatic logic [31:0] get_dat(int k);
      case (k)
         0: return {22'd0, dat0};
         1: return {22'd0, dat1};
         default: return {24'd0, dat2};
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: compare every instance to the model mid-cycle, then advance the model.
   task automatic tick();
      bit in_hs, out_hs;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("valid%0d", k), get_vld(k), {31'd0, m_pend[k]});
         check($sformatf("ready%0d", k), get_rdy(k), {31'd0, (!m_pend[k] || dout_ready[k])});
         check($sformatf("data%0d", k), get_dat(k), m_res[k]);
         if (rst) begin
            m_n[k] = 0; m_sum[k] = 0; m_pend[k] = 1'b0; m_res[k] = 0;
         end else begin
            in_hs  = din_valid[k] && (!m_pend[k] || dout_ready[k]);
            out_hs = m_pend[k] && dout_ready[k];
            if (out_hs) m_pend[k] = 1'b0;
            if (in_hs) begin
               m_sum[k] += ext_val(k, din_data[k]);
               m_n[k]++;
               if (m_n[k] == cnt_of(k)) begin
                  m_res[k]  = m_sum[k] & mask_of(k);
                  m_pend[k] = 1'b1;
                  m_n[k]    = 0;
                  m_sum[k]  = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [7:0] d, logic v, logic r);
      for (int k = 0; k < 3; k++) begin
         din_data[k]   = d;
         din_valid[k]  = v;
         dout_ready[k] = r;
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din_data[k] = 8'd0; din_valid[k] = 1'b0; dout_ready[k] = 1'b1;
         m_n[k] = 0; m_sum[k] = 0; m_pend[k] = 1'b0; m_res[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, vld0}, 32'd0);
      check("rst_data", {22'd0, dat0}, 32'd0);
      rst = 1'b0;
      drive(8'd0, 1'b0, 1'b1);
      check("ready_after_rst", {31'd0, rdy0}, 32'd1);

      // Unsigned and signed sum of 1,2,3,4.
      drive(8'd1, 1'b1, 1'b1); drive(8'd2, 1'b1, 1'b1); drive(8'd3, 1'b1, 1'b1); drive(8'd4, 1'b1, 1'b1);
      check("uns_sum_valid", {31'd0, vld0}, 32'd1);
      check("uns_sum", {22'd0, dat0}, 32'd10);
      drive(8'd0, 1'b0, 1'b1);
      check("uns_one_cycle", {31'd0, vld0}, 32'd0);

      // -3, 5, -7, 1.
      drive(8'hFD, 1'b1, 1'b1); drive(8'h05, 1'b1, 1'b1); drive(8'hF9, 1'b1, 1'b1); drive(8'h01, 1'b1, 1'b1);
`ifdef DIFF_ACCUM_ABS_EN
      check("sgn_sum", {22'd0, dat1}, 32'd16);
`else
      check("sgn_sum", {22'd0, dat1}, 32'h3FC);
`endif
      check("uns_wrap_sum", {22'd0, dat0}, 32'd508);
      drive(8'd0, 1'b0, 1'b1);

      // Four samples of -128: 512 as abs sum and as -512 mod 1024.
      repeat (4) drive(8'h80, 1'b1, 1'b1);
      check("min_sum", {22'd0, dat1}, 32'd512);
      drive(8'd0, 1'b0, 1'b1);

      // Backpressure, then simultaneous handshake with sample 7.
      repeat (3) drive(8'd1, 1'b1, 1'b1);
      drive(8'd1, 1'b1, 1'b0);
      repeat (5) drive(8'h55, 1'b1, 1'b0);
      check("stall_ready", {31'd0, rdy0}, 32'd0);
      check("stall_data", {22'd0, dat0}, 32'd4);
      drive(8'd7, 1'b1, 1'b1);
      repeat (3) drive(8'd1, 1'b1, 1'b1);
      check("after_stall_sum", {22'd0, dat0}, 32'd10);
      drive(8'd0, 1'b0, 1'b1);

      // Back-to-back windows of ones.
      repeat (4) drive(8'd1, 1'b1, 1'b1);
      check("b2b_first", {22'd0, dat0}, 32'd4);
      repeat (4) drive(8'd1, 1'b1, 1'b1);
      check("b2b_second_valid", {31'd0, vld0}, 32'd1);
      drive(8'd0, 1'b0, 1'b1);

      // Reset mid-window.
      repeat (2) drive(8'd9, 1'b1, 1'b1);
      rst = 1'b1; drive(8'd0, 1'b0, 1'b1); rst = 1'b0;
      repeat (4) drive(8'd1, 1'b1, 1'b1);
      check("rst_mid_sum", {22'd0, dat0}, 32'd4);
      drive(8'd0, 1'b0, 1'b1);

      // Reset while the output is stalled.
      repeat (4) drive(8'd2, 1'b1, 1'b0);
      drive(8'd0, 1'b0, 1'b0);
      rst = 1'b1; drive(8'd0, 1'b0, 1'b0); rst = 1'b0;
      check("rst_stall_valid", {31'd0, vld0}, 32'd0);
      check("rst_stall_data", {22'd0, dat0}, 32'd0);
      drive(8'd0, 1'b0, 1'b1);

      // CNT=1 stream 5, 6, 7.
      drive(8'd5, 1'b1, 1'b1);
      check("cnt1_a", {24'd0, dat2}, 32'd5);
      drive(8'd6, 1'b1, 1'b1);
      check("cnt1_b", {24'd0, dat2}, 32'd6);
      drive(8'd7, 1'b1, 1'b1);
      check("cnt1_c", {24'd0, dat2}, 32'd7);
      check("cnt1_valid", {31'd0, vld2}, 32'd1);
      drive(8'd0, 1'b0, 1'b1);

      // Random traffic with independent valid/ready and occasional reset.
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 3; k++) begin
            din_valid[k]  = ($urandom_range(0, 3) != 0);
            din_data[k]   = 8'($urandom);
            dout_ready[k] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0;
      drive(8'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
